// File: rtl/mdu_seq_ctrl.sv
// Multiply/divide sequencer: captures the result on issue, holds busy for a
// fixed latency, then commits HI/LO with a one-cycle done pulse.
`timescale 1ns/1ps
module mdu_seq_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  mdop,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  localparam logic [7:0] MULT_LAST = 8'(MULT_CYCLES - 1);
  localparam logic [7:0] DIV_LAST  = 8'(DIV_CYCLES - 1);

  typedef enum logic {IDLE, RUN} state_t;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } md_res_t;

  state_t      state, state_nx;
  logic [7:0]  cnt;
  md_res_t     pend;
  logic        issue, is_md, commit, sgn;
  logic [63:0] ax, bx, prod;
  logic [31:0] num, den, den_safe, q_mag, r_mag, quo, rem;

  // state register
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // next state
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (issue && is_md) state_nx = RUN;
      RUN:     if (cnt == 8'd0)    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // outputs / control decode
  always_comb begin
    busy   = (state == RUN);
    issue  = start && !flush && (state == IDLE);
    is_md  = (mdop >= 3'd1) && (mdop <= 3'd4);
    commit = (state == RUN) && (cnt == 8'd0);
  end

  // One multiplier for both signednesses (conditional sign extension), and a
  // sign-magnitude divider so 0x80000000 / -1 wraps to 0x80000000 naturally.
  always_comb begin
    sgn      = (mdop == 3'd1) || (mdop == 3'd3);
    ax       = {{32{sgn & A[31]}}, A};
    bx       = {{32{sgn & B[31]}}, B};
    prod     = ax * bx;
    num      = (sgn & A[31]) ? -A : A;
    den      = (sgn & B[31]) ? -B : B;
    den_safe = (den == 32'd0) ? 32'd1 : den;
    q_mag    = num / den_safe;
    r_mag    = num % den_safe;
    quo      = (sgn & (A[31] ^ B[31])) ? -q_mag : q_mag;
    rem      = (sgn & A[31]) ? -r_mag : r_mag;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt  <= 8'd0;
      pend <= '0;
      done <= 1'b0;
      hi   <= 32'd0;
      lo   <= 32'd0;
    end else begin
      done <= commit;
      if (commit) begin
        // divide-by-zero still runs full latency but leaves HI/LO alone
        if (!pend.dz) begin
          hi <= pend.hi;
          lo <= pend.lo;
        end
      end else if (state == RUN) begin
        cnt <= cnt - 8'd1;
      end else if (issue) begin
        case (mdop)
          3'd1, 3'd2: begin
            pend <= '{hi: prod[63:32], lo: prod[31:0], dz: 1'b0};
            cnt  <= MULT_LAST;
          end
          3'd3, 3'd4: begin
            pend <= '{hi: rem, lo: quo, dz: (B == 32'd0)};
            cnt  <= DIV_LAST;
          end
          3'd5:    hi <= A;
          3'd6:    lo <= A;
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_mdu_seq_ctrl.sv
// Directed + randomized bench for mdu_seq_ctrl against a wide-arithmetic
// reference model of HI/LO and the busy/done timing.
`timescale 1ns/1ps
module tb_mdu_seq_ctrl;
  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0, reset = 1'b0, start = 1'b0, flush = 1'b0;
  logic [2:0]  mdop = 3'd0;
  logic [31:0] A = 32'd0, B = 32'd0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int          nchk = 0, nerr = 0;
  logic [31:0] mhi = 32'd0, mlo = 32'd0;

  mdu_seq_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .start(start), .mdop(mdop), .A(A), .B(B),
    .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    nchk++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: results from 64-bit native arithmetic
  function automatic void ref_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] rh, output logic [31:0] rl, output bit valid);
    longint      sa, sb, q, r;
    logic [63:0] p;
    valid = 1'b1; rh = mhi; rl = mlo;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      3'd1: begin p = 64'(sa * sb); rh = p[63:32]; rl = p[31:0]; end
      3'd2: begin p = {32'd0, a} * {32'd0, b}; rh = p[63:32]; rl = p[31:0]; end
      3'd3: if (b == 0) valid = 1'b0;
            else begin q = sa / sb; r = sa % sb; rl = q[31:0]; rh = r[31:0]; end
      3'd4: if (b == 0) valid = 1'b0;
            else begin rl = a / b; rh = a % b; end
      default: valid = 1'b0;
    endcase
  endfunction

  // inj: 0 none, 1 mtlo start during RUN, 2 flush during RUN, 3 reset during RUN
  task automatic run_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int inj_at, input int inj);
    logic [31:0] rh, rl;
    bit          valid;
    int          n;
    ref_md(op, a, b, rh, rl, valid);
    n = (op <= 3'd2) ? MC : DC;
    start = 1'b1; mdop = op; A = a; B = b;
    tick();
    start = 1'b0; mdop = 3'd0;
    for (int i = 0; i < n; i++) begin
      chk("run", {30'd0, busy, done, hi, lo}, {30'd0, 2'b10, mhi, mlo});
      if (i == inj_at) begin
        case (inj)
          1: begin start = 1'b1; mdop = 3'd6; A = 32'hDEAD; end
          2: flush = 1'b1;
          3: begin
            reset = 1'b0;
            #2;
            chk("rst_no_edge", {63'd0, busy, hi, lo}, {63'd0, 1'b1, mhi, mlo});
            tick();
            reset = 1'b1; mhi = 32'd0; mlo = 32'd0;
            chk("rst_abort", {30'd0, busy, done, hi, lo}, 96'd0);
            tick();
            chk("rst_no_done", {30'd0, busy, done, hi, lo}, 96'd0);
            return;
          end
          default: ;
        endcase
      end
      tick();
      start = 1'b0; flush = 1'b0; mdop = 3'd0;
    end
    if (valid) begin mhi = rh; mlo = rl; end
    chk("commit", {30'd0, busy, done, hi, lo}, {30'd0, 2'b01, mhi, mlo});
  endtask

  // single-edge issue: mthi/mtlo/nop, or any op killed by flush
  task automatic one_shot(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit fl);
    start = 1'b1; mdop = op; A = a; B = b; flush = fl;
    tick();
    start = 1'b0; flush = 1'b0; mdop = 3'd0;
    if (!fl && op == 3'd5) mhi = a;
    if (!fl && op == 3'd6) mlo = a;
    chk("one_shot", {30'd0, busy, done, hi, lo}, {30'd0, 2'b00, mhi, mlo});
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  initial begin
    logic [2:0] op;
    bit         fl;
    tick(); tick();
    chk("reset", {30'd0, busy, done, hi, lo}, 96'd0);
    reset = 1'b1;
    tick();

    run_md(3'd1, 32'hFFFF_FFFE, 32'd3, -1, 0);
    chk("t1_mult", {32'd0, hi, lo}, {32'd0, 64'hFFFF_FFFF_FFFF_FFFA});

    run_md(3'd4, 32'd100, 32'd7, -1, 0);
    chk("t2_divu", {32'd0, hi, lo}, {32'd0, 32'd2, 32'd14});
    run_md(3'd3, 32'hFFFF_FFF9, 32'd2, -1, 0);
    chk("t2_div", {32'd0, hi, lo}, {32'd0, 64'hFFFF_FFFF_FFFF_FFFD});
    run_md(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, -1, 0);
    chk("div_ovf", {32'd0, hi, lo}, {32'd0, 32'd0, 32'h8000_0000});

    one_shot(3'd5, 32'h11, 32'd0, 1'b0);
    one_shot(3'd6, 32'h22, 32'd0, 1'b0);
    run_md(3'd3, 32'd5, 32'd0, -1, 0);
    chk("t3_dz", {32'd0, hi, lo}, {32'd0, 32'h11, 32'h22});
    run_md(3'd4, 32'd9, 32'd0, -1, 0);
    chk("t3_dzu", {32'd0, hi, lo}, {32'd0, 32'h11, 32'h22});

    run_md(3'd1, 32'd1234, 32'd5678, 1, 1);
    chk("t4_mtlo_ign", {32'd0, hi, lo}, {32'd0, 64'd7006652});
    run_md(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, 0);
    chk("t4_b2b", {32'd0, hi, lo}, {32'd0, 64'hFFFF_FFFE_0000_0001});

    one_shot(3'd1, 32'd7, 32'd9, 1'b1);
    one_shot(3'd5, 32'hBAD, 32'd0, 1'b1);
    one_shot(3'd0, 32'h1, 32'd0, 1'b0);
    one_shot(3'd7, 32'h2, 32'd0, 1'b0);
    run_md(3'd1, 32'hFFFF_FFFD, 32'hFFFF_FFFC, 2, 2);
    chk("t5_flush_run", {32'd0, hi, lo}, {32'd0, 64'd12});

    run_md(3'd3, 32'd1000, 32'd3, 3, 3);
    chk("t6_rst", {32'd0, hi, lo}, 96'd0);

    for (int k = 0; k < 40; k++) begin
      op = 3'($urandom_range(0, 7));
      fl = ($urandom_range(0, 4) == 0);
      if (op >= 3'd1 && op <= 3'd4 && !fl) run_md(op, pick(), pick(), -1, 0);
      else                                 one_shot(op, pick(), pick(), fl);
    end

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
